// File: rtl/ram_port_master.sv
// ram_port_master: initiator for a single-port synchronous RAM. It accepts single
// read/write requests and a whole-array clear over a valid/ready channel, then returns a
// one-cycle response pulse. Every output is registered. The outputs are computed from the
// next state, so they line up with the state the FSM is entering.
// Optional feature: define RAM_PORT_MASTER_VERIFY_EN to read back and compare each write.
module ram_port_master #(
  parameter int unsigned       ADDR_W       = 5,
  parameter int unsigned       DATA_W       = 9,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_error,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic              o_ram_wren,
  output logic [DATA_W-1:0] o_ram_write,
  input  logic [DATA_W-1:0] i_ram_read
);

  // A READ_LATENCY of 1..3 fits in two bits.
  localparam int unsigned       CntW    = 2;
  localparam logic [CntW-1:0]   LatLoad = CntW'(READ_LATENCY);
  localparam logic [ADDR_W-1:0] LastIdx = '1;
  localparam logic [1:0]        OpWrite = 2'b01;
  localparam logic [1:0]        OpClear = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdAddr,
    StRdWait,
    StClear,
    StVfyWait
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_req_ready;
  logic                w_req_ready_d;
  logic                r_rsp_valid;
  logic                w_rsp_valid_d;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [DATA_W-1:0]   w_rsp_rdata_d;
  logic                r_rsp_error;
  logic                w_rsp_error_d;
  logic [ADDR_W-1:0]   r_ram_address;
  logic [ADDR_W-1:0]   w_ram_address_d;
  logic                r_ram_wren;
  logic                w_ram_wren_d;
  logic [DATA_W-1:0]   r_ram_write;
  logic [DATA_W-1:0]   w_ram_write_d;
  logic [CntW-1:0]     r_cnt;
  logic [CntW-1:0]     w_cnt_d;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_d;

  // Next-state and next-output decode; the request fields are latched straight into the
  // RAM address/data registers, which then hold for the whole operation.
  always_comb begin
    w_state_d       = r_state;
    w_req_ready_d   = r_req_ready;
    w_rsp_valid_d   = 1'b0;
    w_rsp_rdata_d   = r_rsp_rdata;
    w_rsp_error_d   = r_rsp_error;
    w_ram_address_d = r_ram_address;
    w_ram_wren_d    = 1'b0;
    w_ram_write_d   = r_ram_write;
    w_cnt_d         = r_cnt;
    w_idx_d         = r_idx;

    unique case (r_state)
      StIdle: begin
        w_req_ready_d = 1'b1;
        if (i_req_valid && r_req_ready) begin
          w_req_ready_d = 1'b0;
          if (i_req_op == OpWrite) begin
            w_state_d       = StWr;
            w_ram_address_d = i_req_addr;
            w_ram_write_d   = i_req_wdata;
            w_ram_wren_d    = 1'b1;
`ifndef RAM_PORT_MASTER_VERIFY_EN
            // Without readback the write completes alongside the RAM write itself.
            w_rsp_valid_d   = 1'b1;
            w_rsp_rdata_d   = '0;
            w_rsp_error_d   = 1'b0;
`endif
          end else if (i_req_op == OpClear) begin
            w_state_d       = StClear;
            w_idx_d         = '0;
            w_ram_address_d = '0;
            w_ram_write_d   = CLEAR_VALUE;
            w_ram_wren_d    = 1'b1;
          end else begin
            // Reserved op 11 is a read.
            w_state_d       = StRdAddr;
            w_ram_address_d = i_req_addr;
          end
        end
      end

      StWr: begin
`ifdef RAM_PORT_MASTER_VERIFY_EN
        w_state_d     = StVfyWait;
        w_cnt_d       = LatLoad;
`else
        w_state_d     = StIdle;
        w_req_ready_d = 1'b1;
`endif
      end

      StRdAddr: begin
        w_state_d = StRdWait;
        w_cnt_d   = LatLoad;
      end

      StRdWait: begin
        if (r_cnt == CntW'(1)) begin
          w_state_d     = StIdle;
          w_req_ready_d = 1'b1;
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = i_ram_read;
          w_rsp_error_d = 1'b0;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end

      StClear: begin
        if (r_idx == LastIdx) begin
          w_state_d     = StIdle;
          w_req_ready_d = 1'b1;
        end else begin
          w_idx_d         = r_idx + ADDR_W'(1);
          w_ram_address_d = r_idx + ADDR_W'(1);
          w_ram_write_d   = CLEAR_VALUE;
          w_ram_wren_d    = 1'b1;
          // Completion rides on the final write.
          if (r_idx + ADDR_W'(1) == LastIdx) begin
            w_rsp_valid_d = 1'b1;
            w_rsp_rdata_d = '0;
            w_rsp_error_d = 1'b0;
          end
        end
      end

`ifdef RAM_PORT_MASTER_VERIFY_EN
      StVfyWait: begin
        // The read address with wren low first appears one cycle after the write, so this
        // wait runs one edge longer than a plain read and terminates at zero.
        if (r_cnt == '0) begin
          w_state_d     = StIdle;
          w_req_ready_d = 1'b1;
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = i_ram_read;
          w_rsp_error_d = (i_ram_read != r_ram_write);
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
`endif

      default: begin
        w_state_d     = StIdle;
        w_req_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight request immediately.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_ram_address <= '0;
      r_ram_wren    <= 1'b0;
      r_ram_write   <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
    end else begin
      r_state       <= w_state_d;
      r_req_ready   <= w_req_ready_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_rdata   <= w_rsp_rdata_d;
      r_rsp_error   <= w_rsp_error_d;
      r_ram_address <= w_ram_address_d;
      r_ram_wren    <= w_ram_wren_d;
      r_ram_write   <= w_ram_write_d;
      r_cnt         <= w_cnt_d;
      r_idx         <= w_idx_d;
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_error   = r_rsp_error;
  assign o_ram_address = r_ram_address;
  assign o_ram_wren    = r_ram_wren;
  assign o_ram_write   = r_ram_write;

endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master: behavioural RAM, a shadow memory model, directed cases and
// randomized transactions. Honours RAM_PORT_MASTER_VERIFY_EN when defined.
module tb_ram_port_master;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 9;
  localparam int unsigned RL  = 2;
  localparam logic [DW-1:0] CLR = 9'h0AA;
`ifdef RAM_PORT_MASTER_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_write;
  logic [DW-1:0] ram_read;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram_port_master #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .READ_LATENCY(RL),
    .CLEAR_VALUE (CLR)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_error  (rsp_error),
    .o_ram_address(ram_address),
    .o_ram_wren   (ram_wren),
    .o_ram_write  (ram_write),
    .i_ram_read   (ram_read)
  );

  // Behavioural RAM; in the verify build address 5 reads back with bit 0 flipped.
  logic [DW-1:0] ram_mem  [32];
  logic [DW-1:0] init_mem [32];
  logic [DW-1:0] rd_pipe  [RL];
  logic [DW-1:0] model_mem[32];
  logic          preload;

  function automatic logic [DW-1:0] corrupt_mask(input logic [AW-1:0] a);
    return (VerifyEn && a == AW'(5)) ? 9'h001 : 9'h000;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= init_mem[i];
    end else if (ram_wren) begin
      ram_mem[ram_address] <= ram_write;
    end
    rd_pipe[0] <= ram_mem[ram_address] ^ corrupt_mask(ram_address);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_read = rd_pipe[RL-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(req_ready), 1);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_val({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    check_val({tag, "_rsp_error"}, 32'(rsp_error), 0);
    check_val({tag, "_ram_addr"}, 32'(ram_address), 0);
    check_val({tag, "_ram_wren"}, 32'(ram_wren), 0);
    check_val({tag, "_ram_write"}, 32'(ram_write), 0);
  endtask

  // One complete request: drive, hold valid until the response, check everything.
  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
    int            exp_lat, exp_wr, k, wr_cnt, got_lat;
    logic [DW-1:0] exp_rd, got_rd;
    logic          exp_err, got_err, seen, wr_bad, last_ok;
    if (op == 2'b01) begin
      exp_wr = 1;
      if (VerifyEn) begin
        exp_lat = 3 + RL;
        exp_rd  = wdata ^ corrupt_mask(addr);
        exp_err = (corrupt_mask(addr) != '0);
      end else begin
        exp_lat = 1;
        exp_rd  = '0;
        exp_err = 1'b0;
      end
    end else if (op == 2'b10) begin
      exp_lat = 32;
      exp_wr  = 32;
      exp_rd  = '0;
      exp_err = 1'b0;
    end else begin
      exp_lat = 2 + RL;
      exp_wr  = 0;
      exp_rd  = model_mem[addr] ^ corrupt_mask(addr);
      exp_err = 1'b0;
    end

    @(negedge clk);
    check_val("ready_before", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    k = 0; seen = 1'b0; wr_cnt = 0; wr_bad = 1'b0; last_ok = 1'b0; got_lat = 0;
    got_rd = '0; got_err = 1'b0;
    while (!seen && k < 80) begin
      @(negedge clk);
      k++;
      if (ram_wren) begin
        if (op == 2'b10) begin
          if (ram_address != AW'(wr_cnt) || ram_write != CLR) wr_bad = 1'b1;
        end else if (ram_address != addr || ram_write != wdata) begin
          wr_bad = 1'b1;
        end
        wr_cnt++;
      end
      if (rsp_valid) begin
        seen      = 1'b1;
        got_lat   = k;
        got_rd    = rsp_rdata;
        got_err   = rsp_error;
        last_ok   = (op != 2'b10) || (ram_wren && ram_address == AW'(31));
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check_val("rsp_seen", 32'(seen), 1);
    check_val("rsp_latency", 32'(got_lat), 32'(exp_lat));
    check_val("rsp_rdata", 32'(got_rd), 32'(exp_rd));
    check_val("rsp_error", 32'(got_err), 32'(exp_err));
    check_val("wren_cycles", 32'(wr_cnt), 32'(exp_wr));
    check_val("wr_addr_data", 32'(wr_bad), 0);
    check_val("rsp_with_last", 32'(last_ok), 1);
    @(negedge clk);
    check_val("post_ready", 32'(req_ready), 1);
    check_val("post_rsp_valid", 32'(rsp_valid), 0);
    check_val("post_wren", 32'(ram_wren), 0);
    check_val("rdata_hold", 32'(rsp_rdata), 32'(exp_rd));

    if (op == 2'b01) model_mem[addr] = wdata;
    else if (op == 2'b10) for (int i = 0; i < 32; i++) model_mem[i] = CLR;
  endtask

  task automatic watch_no_rsp(input string tag, input int cycles);
    int cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check_val(tag, 32'(cnt), 0);
  endtask

  task automatic mid_read_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = AW'(7);
    @(posedge clk);
    @(negedge clk);
    check_val("mr_addr", 32'(ram_address), 7);
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    check_reset_outputs("mr");
    @(negedge clk);
    rst = 1'b0;
    watch_no_rsp("mr_no_rsp", 6);
  endtask

  task automatic partial_clear();
    int   k = 0;
    logic found = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = AW'($urandom);
    @(posedge clk);
    while (!found && k < 40) begin
      @(negedge clk);
      k++;
      if (ram_wren && ram_address == AW'(10)) found = 1'b1;
    end
    check_val("pc_reach10", 32'(found), 1);
    check_val("pc_idx10_cycle", 32'(k), 11);
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    check_val("pc_wren_drop", 32'(ram_wren), 0);
    check_val("pc_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_rsp("pc_no_rsp", 4);
    for (int i = 0; i < 10; i++) model_mem[i] = CLR;
  endtask

  initial begin
    int            sel;
    logic [1:0]    op;
    rst       = 1'b1;
    preload   = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      init_mem[i]  = DW'($urandom);
      model_mem[i] = init_mem[i];
    end
    #2;
    check_reset_outputs("rst0");
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst     = 1'b0;

    do_req(2'b01, AW'(13), 9'h1A5);
    do_req(2'b00, AW'(13), 9'h000);
    do_req(2'b11, AW'(13), 9'h000);

    mid_read_reset();

    do_req(2'b10, AW'(3), 9'h155);
    do_req(2'b00, AW'(0), 9'h000);
    do_req(2'b00, AW'(31), 9'h000);

    do_req(2'b01, AW'(0), 9'h011);
    do_req(2'b01, AW'(9), 9'h099);
    do_req(2'b01, AW'(10), 9'h123);
    do_req(2'b01, AW'(11), 9'h045);
    do_req(2'b01, AW'(31), 9'h1FF);
    partial_clear();
    do_req(2'b00, AW'(0), 9'h000);
    do_req(2'b00, AW'(9), 9'h000);
    do_req(2'b00, AW'(10), 9'h000);
    do_req(2'b00, AW'(11), 9'h000);
    do_req(2'b00, AW'(31), 9'h000);

`ifdef RAM_PORT_MASTER_VERIFY_EN
    do_req(2'b01, AW'(5), 9'h100);
    do_req(2'b01, AW'(6), 9'h0F3);
`endif

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) op = 2'b10;
      else if (sel < 9) op = 2'b01;
      else if (sel < 16) op = 2'b00;
      else op = 2'b11;
      do_req(op, AW'($urandom_range(0, 31)), DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
